// File: rtl/spi_pkg.sv
// spi_pkg: shared constants and state type for the SPI responder
package spi_pkg;
  localparam int SPI_WIDTH = 16;
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;
  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT} state_e;
endpackage

// File: rtl/spi_responder_if.sv
// spi_responder_if: SPI pins plus transmit/receive word handshake
interface spi_responder_if import spi_pkg::*; #(
  parameter int WIDTH = SPI_WIDTH
);
  logic sclk;
  logic cs_n;
  logic mosi;
  logic miso;
  logic [WIDTH-1:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic rx_valid;
  logic frame_err;
  logic busy;
  modport master (
    output sclk, cs_n, mosi, tx_data, tx_valid,
    input  miso, tx_ready, rx_data, rx_valid, frame_err, busy
  );
  modport slave (
    input  sclk, cs_n, mosi, tx_data, tx_valid,
    output miso, tx_ready, rx_data, rx_valid, frame_err, busy
  );
endinterface

// File: rtl/spi_responder_sync_edge.sv
// sync_edge: multi-flop synchronizer with registered rise/fall strobes
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q;
  logic prev_q, rise_q, fall_q;
  // resetting to 0 makes a high input always produce a rise strobe once synchronized
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[STAGES-1] & prev_q;
    end
  end
  assign rise_o = rise_q;
  assign fall_o = fall_q;
endmodule

// File: rtl/spi_responder.sv
// spi_responder: mode-0 SPI responder on the system clock with one-word tx buffer
module spi_responder import spi_pkg::*; #(
  parameter int WIDTH = SPI_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic reset,
  spi_responder_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);
  localparam logic [CW-1:0] MAX_CNT = CW'(WIDTH + 1);
  state_e state_q, state_d;
  logic [WIDTH-1:0] buf_q, buf_d, tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic full_q, full_d, miso_q, miso_d, rx_valid_q, rx_valid_d, frame_err_q, frame_err_d;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall, sample, launch, load, wr;
  sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
    .clk(clk), .reset(reset), .d_i(bus.sclk), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_cs (
    .clk(clk), .reset(reset), .d_i(bus.cs_n), .rise_o(cs_rise), .fall_o(cs_fall)
  );
  assign sample = (SPI_CPOL ^ SPI_CPHA) ? sclk_fall : sclk_rise;
  assign launch = (SPI_CPOL ^ SPI_CPHA) ? sclk_rise : sclk_fall;
  assign load = (state_q == IDLE) && cs_fall;
  assign wr = bus.tx_valid && !full_q;
  // mosi only needs a synchronized level, sampled on the sclk strobe
  always_ff @(posedge clk) begin
    if (reset) mosi_q <= '0;
    else mosi_q <= {mosi_q[SYNC_STAGES-2:0], bus.mosi};
  end
  // frame sequencing; the load sees the pre-write buffer, a same-cycle write stays buffered
  always_comb begin
    state_d = state_q;
    buf_d = wr ? bus.tx_data : buf_q;
    full_d = wr | (full_q & ~load);
    tx_sh_d = tx_sh_q;
    rx_sh_d = rx_sh_q;
    rx_data_d = rx_data_q;
    cnt_d = cnt_q;
    rx_valid_d = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      WAIT_IDLE: state_d = cs_rise ? IDLE : WAIT_IDLE;
      IDLE: begin
        if (cs_fall) begin
          state_d = SHIFT;
          tx_sh_d = full_q ? buf_q : '0;
          rx_sh_d = '0;
          cnt_d = '0;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d = IDLE;
          rx_valid_d = cnt_q == FULL_CNT;
          frame_err_d = cnt_q != FULL_CNT;
          rx_data_d = (cnt_q == FULL_CNT) ? rx_sh_q : rx_data_q;
        end else if (sample) begin
          rx_sh_d = {rx_sh_q[WIDTH-2:0], mosi_q[SYNC_STAGES-1]};
          cnt_d = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + 1'b1;
        end else if (launch && cnt_q != '0) begin
          tx_sh_d = {tx_sh_q[WIDTH-2:0], 1'b0};
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
    miso_d = (state_d == SHIFT) ? tx_sh_d[WIDTH-1] : 1'b0;
  end
  // state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT_IDLE;
      buf_q <= '0;
      full_q <= 1'b0;
      tx_sh_q <= '0;
      rx_sh_q <= '0;
      rx_data_q <= '0;
      cnt_q <= '0;
      miso_q <= 1'b0;
      rx_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q <= buf_d;
      full_q <= full_d;
      tx_sh_q <= tx_sh_d;
      rx_sh_q <= rx_sh_d;
      rx_data_q <= rx_data_d;
      cnt_q <= cnt_d;
      miso_q <= miso_d;
      rx_valid_q <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end
  assign bus.miso = miso_q;
  assign bus.tx_ready = ~full_q;
  assign bus.rx_data = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy = state_q == SHIFT;
endmodule

// File: tb/tb_spi_responder.sv
// tb_spi_responder: directed frames against hand-computed expectations
module tb_spi_responder;
  localparam int H = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  int rxv_n = 0;
  int fe_n = 0;
  int rxv0, fe0;
  logic [15:0] miso_word;
  logic miso_or;
  spi_responder_if #(.WIDTH(16)) bus();
  spi_responder #(.WIDTH(16), .SYNC_STAGES(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.rx_valid) rxv_n++;
    if (bus.frame_err) fe_n++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic snap();
    rxv0 = rxv_n;
    fe0 = fe_n;
  endtask
  task automatic write_tx(input logic [15:0] d);
    @(negedge clk);
    bus.tx_data = d;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask
  task automatic start_frame(input bit wr, input logic [15:0] wd);
    @(negedge clk);
    bus.cs_n = 1'b0;
    if (wr) begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("pre_load_busy", 32'(bus.busy), 32'd0);
      bus.tx_data = wd;
      bus.tx_valid = 1'b1;
      @(negedge clk);
      bus.tx_valid = 1'b0;
      check("load_busy", 32'(bus.busy), 32'd1);
      check("load_write_tx_ready", 32'(bus.tx_ready), 32'd0);
      repeat (H - 2) @(negedge clk);
    end else begin
      repeat (H) @(negedge clk);
    end
    miso_word = '0;
    miso_or = 1'b0;
  endtask
  task automatic shift_bits(input int first, input int n, input logic [15:0] w);
    for (int j = first; j < first + n; j++) begin
      bus.mosi = (j < 16) ? w[15-j] : 1'b0;
      repeat (H) @(negedge clk);
      if (j < 16) miso_word[15-j] = bus.miso;
      miso_or = miso_or | bus.miso;
      bus.sclk = 1'b1;
      repeat (H) @(negedge clk);
      bus.sclk = 1'b0;
    end
  endtask
  task automatic end_frame(input int gap);
    repeat (H) @(negedge clk);
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    repeat (gap) @(negedge clk);
  endtask
  initial begin
    bus.sclk = 1'b0;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    bus.tx_data = '0;
    bus.tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_miso", 32'(bus.miso), 32'd0);
    check("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
    check("rst_rx_data", 32'(bus.rx_data), 32'd0);
    check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("rst_frame_err", 32'(bus.frame_err), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    repeat (10) @(negedge clk);
    write_tx(16'hA5C3);
    check("buf_full", 32'(bus.tx_ready), 32'd0);
    snap();
    start_frame(1'b0, 16'h0);
    check("t1_busy", 32'(bus.busy), 32'd1);
    check("t1_tx_ready", 32'(bus.tx_ready), 32'd1);
    shift_bits(0, 16, 16'h1234);
    repeat (H) @(negedge clk);
    bus.cs_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t1_rx_valid_early", 32'(bus.rx_valid), 32'd0);
    @(negedge clk);
    check("t1_rx_valid_timing", 32'(bus.rx_valid), 32'd1);
    repeat (12) @(negedge clk);
    check("t1_miso", 32'(miso_word), 32'hA5C3);
    check("t1_rx_data", 32'(bus.rx_data), 32'h1234);
    check("t1_rx_pulses", rxv_n - rxv0, 32'd1);
    check("t1_err_pulses", fe_n - fe0, 32'd0);
    check("t1_idle_busy", 32'(bus.busy), 32'd0);
    check("t1_idle_miso", 32'(bus.miso), 32'd0);
    snap();
    start_frame(1'b0, 16'h0);
    shift_bits(0, 16, 16'hFFFF);
    end_frame(16);
    check("t2_miso", 32'(miso_word), 32'h0);
    check("t2_rx_data", 32'(bus.rx_data), 32'hFFFF);
    check("t2_rx_pulses", rxv_n - rxv0, 32'd1);
    snap();
    start_frame(1'b0, 16'h0);
    shift_bits(0, 9, 16'h5555);
    end_frame(16);
    check("t3_short_err", fe_n - fe0, 32'd1);
    check("t3_short_rx", rxv_n - rxv0, 32'd0);
    check("t3_short_data", 32'(bus.rx_data), 32'hFFFF);
    snap();
    start_frame(1'b0, 16'h0);
    shift_bits(0, 17, 16'h5555);
    end_frame(16);
    check("t3_long_err", fe_n - fe0, 32'd1);
    check("t3_long_rx", rxv_n - rxv0, 32'd0);
    check("t3_long_data", 32'(bus.rx_data), 32'hFFFF);
    start_frame(1'b1, 16'h0F0F);
    shift_bits(0, 16, 16'h0000);
    end_frame(16);
    check("t4_first_miso", 32'(miso_word), 32'h0);
    check("t4_first_rx", 32'(bus.rx_data), 32'h0);
    check("t4_still_buffered", 32'(bus.tx_ready), 32'd0);
    start_frame(1'b0, 16'h0);
    shift_bits(0, 16, 16'h00FF);
    end_frame(16);
    check("t4_second_miso", 32'(miso_word), 32'h0F0F);
    check("t4_second_rx", 32'(bus.rx_data), 32'h00FF);
    check("t4_tx_ready", 32'(bus.tx_ready), 32'd1);
    write_tx(16'hFFFF);
    snap();
    start_frame(1'b0, 16'h0);
    shift_bits(0, 8, 16'hAAAA);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t5_rst_miso", 32'(bus.miso), 32'd0);
    check("t5_rst_busy", 32'(bus.busy), 32'd0);
    check("t5_rst_rx_data", 32'(bus.rx_data), 32'd0);
    check("t5_rst_tx_ready", 32'(bus.tx_ready), 32'd1);
    miso_or = 1'b0;
    shift_bits(8, 8, 16'hAAAA);
    check("t5_miso_quiet", 32'(miso_or), 32'd0);
    check("t5_busy_quiet", 32'(bus.busy), 32'd0);
    end_frame(16);
    check("t5_rx_pulses", rxv_n - rxv0, 32'd0);
    check("t5_err_pulses", fe_n - fe0, 32'd0);
    write_tx(16'h3C5A);
    snap();
    start_frame(1'b0, 16'h0);
    shift_bits(0, 16, 16'hBEEF);
    end_frame(16);
    check("t5_after_miso", 32'(miso_word), 32'h3C5A);
    check("t5_after_rx", 32'(bus.rx_data), 32'hBEEF);
    check("t5_after_pulses", rxv_n - rxv0, 32'd1);
    snap();
    start_frame(1'b0, 16'h0);
    shift_bits(0, 16, 16'h0001);
    end_frame(5);
    check("t6_first_rx", 32'(bus.rx_data), 32'h0001);
    start_frame(1'b0, 16'h0);
    shift_bits(0, 16, 16'h8000);
    end_frame(16);
    check("t6_second_rx", 32'(bus.rx_data), 32'h8000);
    check("t6_rx_pulses", rxv_n - rxv0, 32'd2);
    check("t6_err_pulses", fe_n - fe0, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
